// File: rtl/sr_excite_seq.sv
// Drives an external SR flip-flop from a FIFO of target words, one bit every three
// cycles (DRIVE, SETTLE, CHECK), and keeps a saturating count of read-back mismatches.
module sr_excite_seq #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             cp,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    output logic             s,
    output logic             r,
    input  logic             q_fb,
    input  logic             err_clr,
    output logic             busy,
    output logic             word_done,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        if (v == {ERR_W{1'b1}}) begin
            return v;
        end else begin
            return v + ERR_W'(1);
        end
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bit_idx;
    logic             r_s;
    logic             r_r;
    logic             r_done;
    logic             r_err;
    logic [ERR_W-1:0] r_err_cnt;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_tgt_bit;
    logic             w_mismatch;
    logic             w_last_check;
    logic             w_err_next;
    logic [ERR_W-1:0] w_err_base;
    logic [ERR_W-1:0] w_err_cnt_next;

    assign w_full       = (r_count == FULL_CNT);
    assign w_empty      = (r_count == {(AW+1){1'b0}});
    assign w_push       = tgt_valid && !w_full;
    assign w_pop        = (r_state == ST_IDLE) && !w_empty;
    assign w_mismatch   = (r_state == ST_CHECK) && (q_fb != r_shift[0]);
    assign w_last_check = (r_state == ST_CHECK) && (r_bit_idx == LAST_IDX);
    // Target for the bit about to be driven: FIFO head on a fresh word, else the next shift bit.
    assign w_tgt_bit    = (r_state == ST_IDLE) ? r_mem[r_rd_ptr][0] : r_shift[1];

    // A clear coincident with a mismatch lands first, so the mismatch still counts.
    assign w_err_base     = err_clr ? {ERR_W{1'b0}} : r_err_cnt;
    assign w_err_cnt_next = w_mismatch ? sat_inc(w_err_base) : w_err_base;
    assign w_err_next     = (r_err && !err_clr) || w_mismatch;

    // Next-state logic of the per-bit sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_next_state = ST_DRIVE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DRIVE:  w_next_state = ST_SETTLE;
            ST_SETTLE: w_next_state = ST_CHECK;
            ST_CHECK: begin
                if (r_bit_idx == LAST_IDX) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DRIVE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge cp) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tgt_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge cp or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencer state, word shifter, excitation drive and error tracking.
    always_ff @(posedge cp or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= {WIDTH{1'b0}};
            r_bit_idx <= {BW{1'b0}};
            r_s       <= 1'b0;
            r_r       <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= {ERR_W{1'b0}};
        end else begin
            r_state   <= w_next_state;
            r_done    <= w_last_check;
            r_err     <= w_err_next;
            r_err_cnt <= w_err_cnt_next;
            if (w_pop) begin
                r_shift   <= r_mem[r_rd_ptr];
                r_bit_idx <= {BW{1'b0}};
            end else if ((r_state == ST_CHECK) && !w_last_check) begin
                r_shift   <= {1'b0, r_shift[WIDTH-1:1]};
                r_bit_idx <= r_bit_idx + BW'(1);
            end
            // Excitation: set only for 0->1, reset only for 1->0, otherwise hold.
            if (w_next_state == ST_DRIVE) begin
                r_s <= !q_fb && w_tgt_bit;
                r_r <= q_fb && !w_tgt_bit;
            end else begin
                r_s <= 1'b0;
                r_r <= 1'b0;
            end
        end
    end

    assign tgt_ready = !w_full;
    assign s         = r_s;
    assign r         = r_r;
    assign busy      = (r_state != ST_IDLE);
    assign word_done = r_done;
    assign err_cnt   = r_err_cnt;
    assign err       = r_err;

endmodule

// File: tb/tb_sr_excite_seq.sv
// Bench for sr_excite_seq: behavioural SR flip-flop, word-level reference model,
// a table of directed words, hand-written corner sequences and randomized traffic.
module tb_sr_excite_seq;
    localparam int W = 8;
    localparam int D = 4;
    localparam int STEPS = 3 * W;

    logic       cp = 1'b0;
    logic       rst = 1'b0;
    logic       tgt_valid = 1'b0;
    logic [7:0] tgt_data = 8'h00;
    logic       err_clr = 1'b0;
    logic [1:0] qmode = 2'd0;
    logic       ff_q;
    logic       q_fb;
    logic       tgt_ready, s, r, busy, word_done, err;
    logic [7:0] err_cnt;

    logic       v4 = 1'b0;
    logic [7:0] d4 = 8'h00;
    logic       clr4 = 1'b0;
    logic       qfb4 = 1'b0;
    logic       rdy4, s4, r4, busy4, done4, err4;
    logic [3:0] cnt4;

    int total = 0;
    int bad = 0;
    int held = 0;
    int n_done = 0;

    logic [7:0] mq[$];
    bit         m_active = 1'b0;
    int         m_k = 0;
    logic [7:0] m_word = 8'h00;
    bit         m_done = 1'b0;
    int         m_cnt = 0;
    bit         m_err = 1'b0;
    logic       m_qc = 1'b0;
    logic [7:0] cap_s = 8'h00;
    logic [7:0] cap_r = 8'h00;

    typedef struct {
        logic [7:0] data;
        logic [1:0] mode;
        int         cnt;
        logic       errf;
        logic [7:0] smask;
        logic [7:0] rmask;
    } vec_t;
    vec_t tbl[6];

    sr_excite_seq #(.WIDTH(8), .DEPTH(4), .ERR_W(8)) u_dut (
        .cp(cp), .rst(rst), .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(tgt_ready),
        .s(s), .r(r), .q_fb(q_fb), .err_clr(err_clr), .busy(busy), .word_done(word_done),
        .err_cnt(err_cnt), .err(err)
    );

    sr_excite_seq #(.WIDTH(8), .DEPTH(4), .ERR_W(4)) u_dut4 (
        .cp(cp), .rst(rst), .tgt_valid(v4), .tgt_data(d4), .tgt_ready(rdy4),
        .s(s4), .r(r4), .q_fb(qfb4), .err_clr(clr4), .busy(busy4), .word_done(done4),
        .err_cnt(cnt4), .err(err4)
    );

    always #5 cp = ~cp;

    // External SR flip-flop: samples s/r on every rising edge.
    always @(posedge cp or negedge rst) begin
        if (!rst) ff_q <= 1'b0;
        else if (s) ff_q <= 1'b1;
        else if (r) ff_q <= 1'b0;
    end

    // Read-back path: 0 = true q, 1 = stuck 0, 2 = stuck 1, 3 = inverted.
    assign q_fb = (qmode == 2'd0) ? ff_q : (qmode == 2'd1) ? 1'b0 : (qmode == 2'd2) ? 1'b1 : ~ff_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: compares outputs mid-cycle, then advances to the state after the coming edge.
    always @(negedge cp or negedge rst) begin : model
        int   bi;
        logic mm;
        logic acc;
        if (!rst) begin
            mq.delete();
            m_active = 1'b0;
            m_k = 0;
            m_done = 1'b0;
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            chk("busy", 32'(busy), 32'(m_active));
            chk("word_done", 32'(word_done), 32'(m_done));
            chk("tgt_ready", 32'(tgt_ready), 32'(mq.size() < D));
            chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
            chk("err", 32'(err), 32'(m_err));
            chk("s_and_r", 32'(s & r), 32'(0));
            if (m_active && (m_k % 3 == 0)) begin
                bi = m_k / 3;
                chk("s_drive", 32'(s), 32'(!m_qc && m_word[bi]));
                chk("r_drive", 32'(r), 32'(m_qc && !m_word[bi]));
                cap_s[bi] = s;
                cap_r[bi] = r;
            end else begin
                chk("s_quiet", 32'(s), 32'(0));
                chk("r_quiet", 32'(r), 32'(0));
            end
            if (word_done) n_done++;

            acc = tgt_valid && (mq.size() < D);
            mm = m_active && (m_k % 3 == 2) && (q_fb !== m_word[m_k / 3]);
            if (err_clr) begin
                m_cnt = 0;
                m_err = 1'b0;
            end
            if (mm) begin
                if (m_cnt < 255) m_cnt++;
                m_err = 1'b1;
            end
            m_done = 1'b0;
            if (m_active) begin
                m_k++;
                if (m_k == STEPS) begin
                    m_active = 1'b0;
                    m_done = 1'b1;
                end else if (m_k % 3 == 0) begin
                    m_qc = q_fb;
                end
            end else if (mq.size() != 0) begin
                m_word = mq.pop_front();
                m_active = 1'b1;
                m_k = 0;
                m_qc = q_fb;
                cap_s = 8'h00;
                cap_r = 8'h00;
            end
            if (acc) mq.push_back(tgt_data);
        end
    end

    task automatic tick();
        @(posedge cp);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        int n = 0;
        tgt_valid = 1'b1;
        tgt_data = d;
        while (!tgt_ready && n < 400) begin
            tick();
            n++;
            held++;
        end
        if (n >= 400) chk("push_timeout", 32'(1), 32'(0));
        tick();
        tgt_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_active || mq.size() != 0) && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) chk("idle_timeout", 32'(1), 32'(0));
        tick();
        tick();
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        int p4;
        logic [7:0] fill[6];
        tbl[0] = '{8'hA5, 2'd0, 0, 1'b0, 8'hA5, 8'h4A};
        tbl[1] = '{8'h0F, 2'd0, 0, 1'b0, 8'h00, 8'h10};
        tbl[2] = '{8'hFF, 2'd1, 8, 1'b1, 8'hFF, 8'h00};
        tbl[3] = '{8'h3C, 2'd1, 4, 1'b1, 8'h3C, 8'h00};
        tbl[4] = '{8'h00, 2'd2, 8, 1'b1, 8'h00, 8'hFF};
        tbl[5] = '{8'h5A, 2'd0, 0, 1'b0, 8'h4A, 8'hA4};
        fill[0] = 8'h81; fill[1] = 8'h42; fill[2] = 8'h24;
        fill[3] = 8'h18; fill[4] = 8'hC3; fill[5] = 8'h7E;

        repeat (3) tick();
        chk("rst_s", 32'(s), 32'(0));
        chk("rst_r", 32'(r), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ready", 32'(tgt_ready), 32'(1));
        chk("rst_err_cnt", 32'(err_cnt), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            qmode = tbl[i].mode;
            pulse_clr();
            d0 = n_done;
            push(tbl[i].data);
            wait_idle();
            chk("vec_err_cnt", 32'(err_cnt), 32'(tbl[i].cnt));
            chk("vec_err", 32'(err), 32'(tbl[i].errf));
            chk("vec_smask", 32'(cap_s), 32'(tbl[i].smask));
            chk("vec_rmask", 32'(cap_r), 32'(tbl[i].rmask));
            chk("vec_done", 32'(n_done - d0), 32'(1));
        end
        qmode = 2'd0;

        // Back-to-back pushes until the FIFO fills and holds the producer.
        d0 = n_done;
        held = 0;
        for (int i = 0; i < 6; i++) push(fill[i]);
        chk("fill_held", 32'(held > 0), 32'(1));
        wait_idle();
        chk("fill_done_cnt", 32'(n_done - d0), 32'(6));
        chk("fill_err_cnt", 32'(err_cnt), 32'(0));

        // Clear arriving on the same edge as a mismatch check.
        qmode = 2'd1;
        push(8'hFF);
        wait_idle();
        chk("pre_clr_cnt", 32'(err_cnt), 32'(8));
        push(8'h01);
        n = 0;
        while (!(m_active && m_k == 2) && n < 100) begin
            tick();
            n++;
        end
        chk("clr_sync_found", 32'(n < 100), 32'(1));
        pulse_clr();
        wait_idle();
        chk("clr_mm_cnt", 32'(err_cnt), 32'(1));
        chk("clr_mm_err", 32'(err), 32'(1));
        qmode = 2'd0;
        pulse_clr();

        // Narrow counter saturates at 15 after 16 mismatches.
        v4 = 1'b1;
        d4 = 8'hFF;
        tick();
        tick();
        v4 = 1'b0;
        p4 = 0;
        n = 0;
        while (p4 < 2 && n < 200) begin
            if (done4) p4++;
            tick();
            n++;
        end
        chk("sat_done", 32'(p4), 32'(2));
        chk("sat_cnt", 32'(cnt4), 32'(15));
        chk("sat_err", 32'(err4), 32'(1));
        clr4 = 1'b1;
        tick();
        clr4 = 1'b0;
        chk("sat_clr_cnt", 32'(cnt4), 32'(0));
        chk("sat_clr_err", 32'(err4), 32'(0));

        // Asynchronous reset while bit 3 is being set.
        push(8'h08);
        push(8'h33);
        n = 0;
        while (!(m_active && m_k == 9) && n < 100) begin
            tick();
            n++;
        end
        chk("pre_rst_s", 32'(s), 32'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("async_s", 32'(s), 32'(0));
        chk("async_r", 32'(r), 32'(0));
        chk("async_busy", 32'(busy), 32'(0));
        chk("async_ready", 32'(tgt_ready), 32'(1));
        tick();
        rst = 1'b1;
        tick();
        d0 = n_done;
        push(8'h0F);
        wait_idle();
        chk("post_rst_done", 32'(n_done - d0), 32'(1));
        chk("post_rst_cnt", 32'(err_cnt), 32'(0));

        // Randomized traffic with read-back faults and clears.
        for (int c = 0; c < 500; c++) begin
            qmode = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            err_clr = ($urandom_range(0, 24) == 0);
            tgt_valid = ($urandom_range(0, 3) == 0);
            tgt_data = 8'($urandom);
            tick();
        end
        tgt_valid = 1'b0;
        err_clr = 1'b0;
        qmode = 2'd0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
